apb_master_q: RTL and testbench

//  Parametrised APB master bridge. Accepts read/write requests on a valid/ready port and

---
 rtl/apb_master_q.sv | 230 +++++++++++++++++++++++
 tb/tb_apb_master_q.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_q.sv
// rtl/apb_master_q.sv - APB master bridge with a request queue, chaining, strobes and wait timeout
//
// Purpose:
//   Buffers read/write requests from a valid/ready port in a QDEPTH-entry FIFO. It then issues
//   them as APB transfers. A queued request that is ready when a transfer completes is chained
//   straight into SETUP with no IDLE gap. Each transfer produces a one-cycle response pulse
//   carrying read data, the slave error flag and a timeout flag.
//
// Ports:
//   pclk, presetn                   clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready             request handshake; push on req_valid && req_ready
//   req_write/addr/wdata/strb       request contents
//   rsp_valid/rdata/err/timeout     completion pulse and its fields (no backpressure)
//   busy                            transfer in flight or requests still queued
//   psel/penable/pwrite/paddr/pwdata/pstrb   registered APB outputs
//   pready/prdata/pslverr           APB slave response
`timescale 1ns/1ps
module apb_master_q #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic                busy,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W  = $clog2(QDEPTH + 1);
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  QDEPTH_C  = CNT_W'(QDEPTH);
    // Abort fires on the ACCESS cycle whose increment would bring the counter to TIMEOUT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Request queue storage
    logic [ADDR_W-1:0] r_q_addr  [QDEPTH];
    logic [DATA_W-1:0] r_q_wdata [QDEPTH];
    logic [STRB_W-1:0] r_q_strb  [QDEPTH];
    logic              r_q_write [QDEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    // Held low through reset so req_ready is 0 until the first edge after release
    logic r_rdy_en;

    logic [WAIT_W-1:0] r_wait;

    logic                r_psel;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [DATA_W-1:0]   r_pwdata;
    logic [STRB_W-1:0]   r_pstrb;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_rsp_timeout;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_done;
    logic w_abort;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == QDEPTH_C);
    // No bypass: a full queue refuses even when a pop happens in the same cycle
    assign w_push  = req_valid && req_ready;
    assign w_done  = (r_state == S_ACCESS) && pready;
    assign w_abort = (TIMEOUT != 0) && (r_state == S_ACCESS) && !pready && (r_wait == WAIT_LAST);
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || w_done);

    assign req_ready   = r_rdy_en && !w_full;
    assign busy        = (r_state != S_IDLE) || !w_empty;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

    // Queue storage is not reset; entries are only read once the count covers them
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= req_addr;
            r_q_wdata[r_wr_ptr] <= req_wdata;
            r_q_strb[r_wr_ptr]  <= req_strb;
            r_q_write[r_wr_ptr] <= req_write;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_next_state = S_SETUP;
            S_SETUP:  w_next_state = S_ACCESS;
            S_ACCESS: begin
                if (pready)       w_next_state = w_empty ? S_IDLE : S_SETUP;
                else if (w_abort) w_next_state = S_IDLE;
            end
            default:  w_next_state = S_IDLE;
        endcase
    end

    // FSM registered outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            // Load the queue head into the APB address phase whenever it is popped
            if (w_pop) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_paddr   <= r_q_addr[r_rd_ptr];
                r_pwrite  <= r_q_write[r_rd_ptr];
                r_pwdata  <= r_q_wdata[r_rd_ptr];
                r_pstrb   <= r_q_write[r_rd_ptr] ? r_q_strb[r_rd_ptr] : '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_empty) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_wait    <= '0;
                end
                S_ACCESS: begin
                    if (pready) begin
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        if (w_empty) r_psel <= 1'b0;
                    end else if (w_abort) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_q.sv
// tb/tb_apb_master_q.sv - self-checking bench for apb_master_q with a queue-level reference model
`timescale 1ns/1ps
module tb_apb_master_q;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int QD = 2;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_strb = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata = '0;
    logic          pslverr = 1'b0;

    apb_master_q #(.ADDR_W(AW), .DATA_W(DW), .QDEPTH(QD), .TIMEOUT(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending requests, the request on the bus, and how many
    // cycles it has been on the bus (0 = address phase, n>=1 = n-th data-phase cycle).
    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
    } req_t;

    req_t          mq[$];
    req_t          mcur;
    req_t          m_new;
    bit            m_push  = 1'b0;
    bit            m_act   = 1'b0;
    int            m_age   = 0;
    bit            m_rdy_en = 1'b0;
    bit            m_rv    = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err   = 1'b0;
    bit            m_to    = 1'b0;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mq.delete();
            m_act    = 1'b0;
            m_age    = 0;
            m_rdy_en = 1'b0;
            m_rv     = 1'b0;
        end else begin
            m_push = req_valid && m_rdy_en && (mq.size() < QD);
            m_new  = '{req_write, req_addr, req_wdata, req_strb};
            m_rv   = 1'b0;
            if (!m_act) begin
                if (mq.size() > 0) begin
                    mcur  = mq.pop_front();
                    m_act = 1'b1;
                    m_age = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (pready) begin
                m_rv    = 1'b1;
                m_err   = pslverr;
                m_to    = 1'b0;
                m_rdata = mcur.w ? '0 : prdata;
                if (mq.size() > 0) begin
                    mcur  = mq.pop_front();
                    m_age = 0;
                end else begin
                    m_act = 1'b0;
                end
            end else if (TO != 0 && m_age == TO) begin
                m_rv    = 1'b1;
                m_err   = 1'b1;
                m_to    = 1'b1;
                m_rdata = '0;
                m_act   = 1'b0;
            end else begin
                m_age = m_age + 1;
            end
            if (m_push) mq.push_back(m_new);
            m_rdy_en = 1'b1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge pclk) begin
        chk("psel", psel, m_act);
        chk("penable", penable, m_act && m_age >= 1);
        chk("req_ready", req_ready, m_rdy_en && mq.size() < QD);
        chk("busy", busy, m_act || mq.size() > 0);
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_act) begin
            chk("paddr", paddr, mcur.a);
            chk("pwrite", pwrite, mcur.w);
            if (mcur.w) chk("pwdata", pwdata, mcur.d);
            chk("pstrb", pstrb, mcur.w ? mcur.s : '0);
        end
        if (m_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
    end

    task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            @(negedge pclk);
        end
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int pen;
    bit got;
    int r1;
    int r2;
    bit ps[10];
    bit rv[10];
    bit rdy[4];

    initial begin
        #1 presetn = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk("rst_psel", psel, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        presetn = 1'b1;
        @(negedge pclk);
        chk("post_rst_req_ready", req_ready, 1);

        // T1: write with zero wait states, latency 1/2/3
        drive_req(1'b1, 8'h10, 16'h00A5, 2'b01);
        pready = 1'b1;
        @(negedge pclk);
        req_valid = 1'b0;
        chk("t1_psel_n0", psel, 0);
        @(negedge pclk);
        chk("t1_psel_n1", psel, 1);
        chk("t1_pen_n1", penable, 0);
        chk("t1_paddr", paddr, 8'h10);
        @(negedge pclk);
        chk("t1_pen_n2", penable, 1);
        chk("t1_rv_n2", rsp_valid, 0);
        chk("t1_pwdata", pwdata, 16'h00A5);
        chk("t1_pstrb", pstrb, 2'b01);
        @(negedge pclk);
        chk("t1_rv_n3", rsp_valid, 1);
        chk("t1_err", rsp_err, 0);
        chk("t1_rdata", rsp_rdata, 0);
        wait_idle();

        // T2: read with two wait states
        drive_req(1'b0, 8'h22, 16'h0000, 2'b11);
        pready = 1'b0;
        prdata = 16'h003C;
        @(negedge pclk);
        req_valid = 1'b0;
        pen = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                got = 1'b1;
                chk("t2_rdata", rsp_rdata, 16'h003C);
                chk("t2_err", rsp_err, 0);
            end else begin
                if (penable) begin
                    pen++;
                    chk("t2_pstrb", pstrb, 0);
                end
                pready = (pen >= 3);
            end
        end
        chk("t2_got_rsp", got, 1);
        chk("t2_penable_cycles", pen, 3);
        wait_idle();

        // T3: two back-to-back writes chain without dropping psel
        pready = 1'b1;
        drive_req(1'b1, 8'h30, 16'h1111, 2'b11);
        @(negedge pclk);
        drive_req(1'b1, 8'h31, 16'h2222, 2'b10);
        @(negedge pclk);
        req_valid = 1'b0;
        chk("t3_psel_start", psel, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            ps[i] = psel;
            rv[i] = rsp_valid;
        end
        r1 = -1;
        r2 = -1;
        for (int i = 0; i < 10; i++) begin
            if (rv[i]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        chk("t3_rsp1_at", r1, 1);
        chk("t3_rsp_gap", r2 - r1, 2);
        for (int i = 0; i < 3; i++) chk("t3_psel_held", ps[i], 1);
        chk("t3_psel_end", ps[3], 0);
        wait_idle();

        // T4: read with slave error
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 16'h005A;
        drive_req(1'b0, 8'h44, 16'h0000, 2'b00);
        @(negedge pclk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                got = 1'b1;
                chk("t4_err", rsp_err, 1);
                chk("t4_timeout", rsp_timeout, 0);
                chk("t4_rdata", rsp_rdata, 16'h005A);
            end
        end
        chk("t4_got_rsp", got, 1);
        pslverr = 1'b0;
        wait_idle();

        // T5: wait-state timeout after TO ACCESS cycles
        pready = 1'b0;
        drive_req(1'b0, 8'h55, 16'h0000, 2'b00);
        @(negedge pclk);
        req_valid = 1'b0;
        pen = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                got = 1'b1;
                chk("t5_err", rsp_err, 1);
                chk("t5_timeout", rsp_timeout, 1);
                chk("t5_rdata", rsp_rdata, 0);
                chk("t5_psel", psel, 0);
                chk("t5_busy", busy, 0);
            end else if (penable) begin
                pen++;
            end
        end
        chk("t5_got_rsp", got, 1);
        chk("t5_access_cycles", pen, TO);
        wait_idle();

        // T6: fill the queue while stalled, then reset mid-ACCESS
        pready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_req(1'b1, AW'(8'h60 + k), DW'(16'h0100 * (k + 1)), 2'b11);
            rdy[k] = req_ready;
            @(negedge pclk);
        end
        req_valid = 1'b0;
        chk("t6_ready0", rdy[0], 1);
        chk("t6_ready1", rdy[1], 1);
        chk("t6_ready2", rdy[2], 1);
        chk("t6_ready3", rdy[3], 0);
        chk("t6_pen_before_rst", penable, 1);
        #1 presetn = 1'b0;
        #1;
        chk("t6_rst_psel", psel, 0);
        chk("t6_rst_penable", penable, 0);
        chk("t6_rst_paddr", paddr, 0);
        chk("t6_rst_pwdata", pwdata, 0);
        chk("t6_rst_pstrb", pstrb, 0);
        chk("t6_rst_pwrite", pwrite, 0);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk("t6_no_rsp_in_rst", rsp_valid, 0);
        end
        presetn = 1'b1;
        @(negedge pclk);
        chk("t6_ready_after_rst", req_ready, 1);
        chk("t6_busy_after_rst", busy, 0);

        // Randomized traffic checked by the model, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            if (i == 1500) #1 presetn = 1'b0;
            if (i == 1503) presetn = 1'b1;
            req_valid = ($urandom_range(0, 99) < 60);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            req_strb  = SW'($urandom);
            pready    = ($urandom_range(0, 99) < 65);
            prdata    = DW'($urandom);
            pslverr   = ($urandom_range(0, 99) < 15);
        end
        req_valid = 1'b0;
        pready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
